ldpc_llr_loader: RTL and testbench

- Streaming front-end for the LDPC decoder top.
- Accepts channel LLRs as a multi-lane valid/ready stream and saturates each sample from in_w to data_w.
- Assembles one codeword into the flat R*D*data_w LLR bus the decoder consumes.
- Zero-pads shortened frames, flags length errors, and holds the frame stable until the decoder accepts it.

---
 rtl/ldpc_llr_loader.sv | 173 +++++++++++++++++
 tb/tb_ldpc_llr_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_llr_loader.sv
// ldpc_llr_loader
//   Streaming front-end for the LDPC decoder. It collects channel LLRs from a
//   LANES-wide valid/ready stream, saturates each sample from in_w to data_w
//   bits, and assembles one codeword of N = R*D LLRs on a flat output bus.
//   Shortened frames are zero-padded. Length errors are flagged. The frame is
//   held stable until the decoder accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   cfg_len    LLRs expected in the frame (sampled with the first beat);
//              0 or >N means N
//   in_valid   input beat valid
//   in_ready   loader can accept a beat
//   in_data    LANES samples; lane j at [j*in_w +: in_w], lane 0 earliest
//   in_last    final beat of the frame
//   l_out      LLR k at [(N-k)*data_w-1 -: data_w] (index 0 at MSB)
//   out_valid  l_out holds a complete frame
//   out_ready  decoder accepts the frame
//   err_short  sticky: in_last arrived before cfg_len samples
//   err_long   sticky: cfg_len reached without in_last
module ldpc_llr_loader #(
  parameter int data_w = 12,
  parameter int R      = 24,
  parameter int D      = 24,
  parameter int in_w   = 16,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(R*D+1)-1:0]  cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*in_w-1:0]     in_data,
  input  logic                      in_last,
  output logic [R*D*data_w-1:0]     l_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_short,
  output logic                      err_long
);
  localparam int N  = R*D;
  localparam int CW = $clog2(N+1);
  localparam int PW = CW+1;
  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic signed [in_w-1:0]   SAT_HI_IN  = in_w'(2**(data_w-1)-1);
  localparam logic signed [in_w-1:0]   SAT_LO_IN  = -SAT_HI_IN;
  localparam logic signed [data_w-1:0] SAT_HI_OUT = data_w'(2**(data_w-1)-1);
  localparam logic signed [data_w-1:0] SAT_LO_OUT = -SAT_HI_OUT;

  typedef enum logic [2:0] {IDLE, FILL, DRAIN, PAD, HOLD} state_t;

  // Symmetric clamp: the most negative data_w code is never produced.
  function automatic logic signed [data_w-1:0] sat_llr(input logic signed [in_w-1:0] x);
    if (x > SAT_HI_IN)      return SAT_HI_OUT;
    else if (x < SAT_LO_IN) return SAT_LO_OUT;
    else                    return x[data_w-1:0];
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d, len_q, len_d;
  logic [CW-1:0]            base_c, len_c, cnt_new_c, cfg_eff_c;
  logic                     err_short_q, err_short_d, err_long_q, err_long_d;
  logic                     in_ready_q, out_valid_q;
  logic                     accept_c, wr_beat_c, wr_pad_c;
  logic signed [data_w-1:0] mem_q [N];
  logic [PW-1:0]            pos_c [LANES];
  logic signed [data_w-1:0] wdata_c [LANES];
  logic                     wen_c [LANES];

  assign accept_c  = in_valid && in_ready_q;
  assign cfg_eff_c = (cfg_len == '0 || cfg_len > N_C) ? N_C : cfg_len;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    len_d       = len_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    wr_beat_c   = 1'b0;
    wr_pad_c    = 1'b0;
    // A first beat in IDLE starts at position 0 with the freshly sampled length.
    base_c      = (state_q == IDLE) ? '0 : count_q;
    len_c       = (state_q == IDLE) ? cfg_eff_c : len_q;
    cnt_new_c   = base_c + LANES_C;
    case (state_q)
      IDLE, FILL: begin
        if (accept_c) begin
          wr_beat_c = 1'b1;
          count_d   = cnt_new_c;
          if (state_q == IDLE) begin
            len_d       = cfg_eff_c;
            err_short_d = 1'b0;
            err_long_d  = 1'b0;
          end
          if (in_last) begin
            if (cnt_new_c < len_c) err_short_d = 1'b1;
            state_d = (cnt_new_c < N_C) ? PAD : HOLD;
          end else if (cnt_new_c >= len_c) begin
            err_long_d = 1'b1;
            state_d    = DRAIN;
          end else begin
            state_d = FILL;
          end
        end
      end
      DRAIN: begin
        if (accept_c && in_last) state_d = (count_q < N_C) ? PAD : HOLD;
      end
      PAD: begin
        wr_pad_c = 1'b1;
        count_d  = cnt_new_c;
        if (cnt_new_c >= N_C) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-lane write port: samples beyond len (and all PAD writes) store zero.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      pos_c[j]   = {1'b0, base_c} + PW'(j);
      wen_c[j]   = (wr_beat_c || wr_pad_c) && (pos_c[j] < PW'(N));
      wdata_c[j] = '0;
      if (wr_beat_c && (pos_c[j] < {1'b0, len_c}))
        wdata_c[j] = sat_llr(in_data[j*in_w +: in_w]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= N_C;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      // Registered handshakes track the state being entered.
      in_ready_q  <= (state_d == IDLE) || (state_d == FILL) || (state_d == DRAIN);
      out_valid_q <= (state_d == HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      for (int j = 0; j < LANES; j++)
        if (wen_c[j]) mem_q[pos_c[j][CW-1:0]] <= wdata_c[j];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lout
    assign l_out[(N-k)*data_w-1 -: data_w] = mem_q[k];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Testbench for ldpc_llr_loader: directed frames (nominal, shortened,
// saturation, odd length, early last, overlong, backpressure, reset mid-frame)
// with hand-derived expected LLR images.
module tb_ldpc_llr_loader;
  localparam int DW = 12;
  localparam int R  = 24;
  localparam int D  = 24;
  localparam int IW = 16;
  localparam int L  = 4;
  localparam int N  = R*D;
  localparam int CW = $clog2(N+1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [CW-1:0]   cfg_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [L*IW-1:0] in_data = '0;
  logic            in_last = 1'b0;
  logic [N*DW-1:0] l_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            err_short;
  logic            err_long;

  int n_chk  = 0;
  int n_fail = 0;
  int stim [600];
  int expv [N];

  ldpc_llr_loader #(.data_w(DW), .R(R), .D(D), .in_w(IW), .LANES(L)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .l_out(l_out), .out_valid(out_valid), .out_ready(out_ready),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expd);
    n_chk++;
    if (obs !== expd) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expd);
    end
  endtask

  function automatic int llr(input int k);
    return int'($signed(l_out[(N-k)*DW-1 -: DW]));
  endfunction

  task automatic fill_stim(input int mode);
    for (int k = 0; k < 600; k++) begin
      case (mode)
        0:       stim[k] = (k % 100) - 50;
        1:       stim[k] = ((k * 7) % 200) - 100;
        default: stim[k] = (k % 151) - 75;
      endcase
    end
  endtask

  function automatic void build_exp(input int nvalid);
    for (int k = 0; k < N; k++) expv[k] = (k < nvalid) ? stim[k] : 0;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_beat(input int b, input bit last);
    int   n;
    logic rdy;
    n = 0;
    rdy = 1'b0;
    for (int j = 0; j < L; j++) in_data[j*IW +: IW] = IW'(stim[b*L+j]);
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("beat_accept_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_frame(input int cfg, input int nbeats);
    cfg_len = CW'(cfg);
    for (int b = 0; b < nbeats; b++) send_beat(b, b == nbeats - 1);
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_pad_cycles"}, n, exp_cyc);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic check_frame(input string tag);
    for (int k = 0; k < N; k++) check($sformatf("%s_llr[%0d]", tag, k), llr(k), expv[k]);
  endtask

  task automatic accept_frame(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, out_valid, 0);
    check({tag, "_hs_in_ready"}, in_ready, 1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_long", err_long, 0);
    check("rst_l_out_any", |l_out, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("rel_in_ready_after_edge", in_ready, 1);

    // Nominal full frame
    fill_stim(0);
    build_exp(576);
    run_frame(576, 144);
    wait_valid("nom", 0);
    check("nom_err_short", err_short, 0);
    check("nom_err_long", err_long, 0);
    check_frame("nom");
    accept_frame("nom");

    // Shortened frame: 288 samples, 72 PAD cycles
    fill_stim(1);
    build_exp(288);
    run_frame(288, 72);
    wait_valid("short", 72);
    check("short_err_short", err_short, 0);
    check("short_err_long", err_long, 0);
    check_frame("short");
    accept_frame("short");

    // Saturation, single-beat frame with in_last on the first beat
    stim[0] = 3000; stim[1] = -3000; stim[2] = -2048; stim[3] = 2047;
    build_exp(0);
    expv[0] = 2047; expv[1] = -2047; expv[2] = -2047; expv[3] = 2047;
    run_frame(4, 1);
    wait_valid("sat", 143);
    check("sat_err_short", err_short, 0);
    check_frame("sat");
    accept_frame("sat");

    // Length not a multiple of LANES: positions 10,11 written as zero
    fill_stim(0);
    build_exp(10);
    run_frame(10, 3);
    wait_valid("odd", 141);
    check("odd_err_short", err_short, 0);
    check("odd_err_long", err_long, 0);
    check_frame("odd");
    accept_frame("odd");

    // Early last on beat 10
    fill_stim(1);
    build_exp(40);
    run_frame(576, 10);
    wait_valid("early", 134);
    check("early_err_short", err_short, 1);
    check("early_err_long", err_long, 0);
    check_frame("early");
    accept_frame("early");

    // Overlong: 150 beats, beats 145..150 discarded; err_short cleared
    fill_stim(2);
    build_exp(576);
    run_frame(576, 150);
    wait_valid("long", 0);
    check("long_err_long", err_long, 1);
    check("long_err_short", err_short, 0);
    check_frame("long");

    // Backpressure: frame held for 20 cycles
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_llr0", llr(0), expv[0]);
      check("bp_llr575", llr(575), expv[575]);
    end
    check("bp_err_long", err_long, 1);
    accept_frame("bp");

    // Asynchronous reset mid-FILL
    fill_stim(0);
    cfg_len = CW'(576);
    for (int b = 0; b < 5; b++) send_beat(b, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("amid_out_valid", out_valid, 0);
    check("amid_in_ready", in_ready, 0);
    check("amid_l_out_any", |l_out, 0);
    check("amid_llr0", llr(0), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("amid_rel_in_ready", in_ready, 1);

    // Frame after reset starts from position 0
    fill_stim(1);
    build_exp(576);
    run_frame(576, 144);
    wait_valid("post", 0);
    check("post_err_short", err_short, 0);
    check("post_err_long", err_long, 0);
    check_frame("post");
    accept_frame("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
